// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared types and constants for the stopwatch counter.
//   sw_state_e : controller states (IDLE / RUN / PAUSE)
//   SEG_0..9   : active-low 7-segment codes, bit0 = a .. bit6 = g
//   SEG_BLANK  : all segments off, used for non-BCD codes
//   to_bcd16   : constant-only helper that turns an integer into 4 BCD digits
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Only ever evaluated on parameters at elaboration time, so the divide and
  // modulo here never turn into hardware.
  function automatic logic [15:0] to_bcd16(input int value);
    int v;
    logic [15:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctr_if.sv
// stopwatch_ctr_if -- control and display signals of the stopwatch counter.
//   start, stop, clr, dir : controls driven by the master
//   lap                   : lap-hold toggle, only with STOPWATCH_LAP_EN
//   seg                   : DIGITS x 7 active-low segment lines
//   hb, running, tc       : status driven by the counter (slave)
interface stopwatch_ctr_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic                  stop;
  logic                  clr;
  logic                  dir;
`ifdef STOPWATCH_LAP_EN
  logic                  lap;
`endif
  logic [DIGITS*7-1:0]   seg;
  logic                  hb;
  logic                  running;
  logic                  tc;

`ifdef STOPWATCH_LAP_EN
  modport master (output start, stop, clr, dir, lap, input seg, hb, running, tc);
  modport slave  (input start, stop, clr, dir, lap, output seg, hb, running, tc);
`else
  modport master (output start, stop, clr, dir, input seg, hb, running, tc);
  modport slave  (input start, stop, clr, dir, output seg, hb, running, tc);
`endif
endinterface

// File: rtl/seg7_dec.sv
// seg7_dec -- one BCD digit to active-low 7-segment code.
//   bcd : 4-bit BCD digit in
//   seg : segments out, bit0 = a .. bit6 = g, 0 = lit
import stopwatch_pkg::*;

module seg7_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/stopwatch_ctr.sv
// stopwatch_ctr -- BCD stopwatch with prescaler, up/down count and 7-seg out.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stopwatch_ctr_if.slave (start/stop/clr/dir[/lap] in,
//           seg/hb/running/tc out)
// Optional feature: define STOPWATCH_LAP_EN to add the lap-hold display
// freeze; without it seg always shows the live count.
import stopwatch_pkg::*;

module stopwatch_ctr #(
  parameter int TICK_DIV = 50000000,
  parameter int DIGITS   = 2,
  parameter int MODULUS  = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  stopwatch_ctr_if.slave  bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = DIGITS * 4;
  localparam logic [15:0]   MAX_BCD16 = to_bcd16(MODULUS - 1);
  localparam logic [CW-1:0] MAX_BCD   = MAX_BCD16[CW-1:0];

  sw_state_e           state_reg, state_next;
  logic [PW-1:0]       presc_reg, presc_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [CW-1:0]       inc_val, dec_val, disp_val;
  logic [DIGITS-1:0]   carry, borrow;   // carry/borrow into digit gi
  logic [DIGITS*7-1:0] seg_val;
  logic                hb_reg, tc_reg, tick, wrap, at_max, at_zero;

  // Controller: stop has priority over start while running.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_PAUSE: if (bus.start && !bus.stop) state_next = ST_RUN;
      ST_RUN:            if (bus.stop) state_next = ST_PAUSE;
      default:           state_next = ST_IDLE;
    endcase
  end

  // Prescaler only advances while staying in RUN, so leaving RUN drops any
  // partial prescale and every RUN entry starts a fresh TICK_DIV window.
  assign tick = (state_reg == ST_RUN) && (presc_reg == PW'(TICK_DIV - 1));

  always_comb begin
    presc_next = '0;
    if (state_reg == ST_RUN && state_next == ST_RUN && !tick)
      presc_next = presc_reg + PW'(1);
  end

  // Per-digit ripple increment/decrement and display decoders.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d = count_reg[gi*4 +: 4];
      if (gi == 0) begin : g_lsd
        assign carry[gi]  = 1'b1;
        assign borrow[gi] = 1'b1;
      end else begin : g_upper
        assign carry[gi]  = carry[gi-1]  && (count_reg[(gi-1)*4 +: 4] == 4'd9);
        assign borrow[gi] = borrow[gi-1] && (count_reg[(gi-1)*4 +: 4] == 4'd0);
      end
      assign inc_val[gi*4 +: 4] = !carry[gi]  ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
      assign dec_val[gi*4 +: 4] = !borrow[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);

      seg7_dec u_dec (
        .bcd (disp_val[gi*4 +: 4]),
        .seg (seg_val[gi*7 +: 7])
      );
    end
  endgenerate

  assign at_max  = (count_reg == MAX_BCD);
  assign at_zero = (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    wrap       = 1'b0;
    if (tick) begin
      if (!bus.dir) begin
        count_next = at_max ? '0 : inc_val;
        wrap       = at_max;
      end else begin
        count_next = at_zero ? MAX_BCD : dec_val;
        wrap       = at_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      count_reg <= '0;
      hb_reg    <= 1'b0;
      tc_reg    <= 1'b0;
    end else if (bus.clr) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      count_reg <= '0;
      hb_reg    <= 1'b0;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      count_reg <= count_next;
      hb_reg    <= hb_reg ^ tick;
      tc_reg    <= wrap;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic          lap_prev_reg, hold_reg;
  logic [CW-1:0] held_reg;

  // lap_prev keeps tracking through clr so a held-high lap is not seen as
  // a fresh edge once clr drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_prev_reg <= 1'b0;
      hold_reg     <= 1'b0;
      held_reg     <= '0;
    end else begin
      lap_prev_reg <= bus.lap;
      if (bus.clr) begin
        hold_reg <= 1'b0;
      end else if (bus.lap && !lap_prev_reg) begin
        hold_reg <= !hold_reg;
        if (!hold_reg) held_reg <= count_reg;
      end
    end
  end

  assign disp_val = hold_reg ? held_reg : count_reg;
`else
  assign disp_val = count_reg;
`endif

  assign bus.seg     = seg_val;
  assign bus.hb      = hb_reg;
  assign bus.running = (state_reg == ST_RUN);
  // A wrap on the very tick where stop is taken lands in PAUSE; tc is masked
  // there so it is only ever seen while running.
  assign bus.tc      = tc_reg && (state_reg == ST_RUN);

endmodule
